seg_scan_driver: RTL

Time-multiplexed N-digit hex seven-segment display driver. Accepts a packed hex word with per-digit blank and decimal-point masks. Holds them in a tear-free double buffer and scans one digit at a time, with a dead-time gap between digits. Sits between the clock/counter datapath and the board's shared segment bus and digit-enable lines.

---
 rtl/seg_scan_driver.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex seven-segment scanner with a tear-free pending/display buffer pair.
// Optional leading-zero suppression is enabled by defining SEG_LZ_SUPPRESS_EN.
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_value,
    input  logic [DIGITS-1:0]     in_blank,
    input  logic [DIGITS-1:0]     in_dp,
    input  logic                  load,
    output logic [6:0]            out_seg,
    output logic                  out_dp,
    output logic [DIGITS-1:0]     out_dig,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h73;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h0D;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h6F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_value_q, pend_value_d, disp_value_q, disp_value_d;
    logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     dig_q, dig_d;
    logic                  fd_q, fd_d;

    logic                  cnt_last, idx_last, frame_end;
    logic [3:0]            nibble;
    logic                  lz_dark;
    logic [6:0]            seg_raw;
    logic                  dp_raw;
    logic [DIGITS-1:0]     dig_raw;

`ifdef SEG_LZ_SUPPRESS_EN
    // nz_tail[i] is set when any nibble from i upward is nonzero.
    logic [DIGITS:0] nz_tail;
    assign nz_tail[DIGITS] = 1'b0;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz_tail
            assign nz_tail[gi] = (disp_value_q[4*gi +: 4] != 4'h0) | nz_tail[gi+1];
        end
    endgenerate
    assign lz_dark = (idx_q != '0) && !nz_tail[idx_q];
`else
    assign lz_dark = 1'b0;
`endif

    always_comb begin
        cnt_last  = (cnt_q == CW'(SCAN_DIV - 1));
        idx_last  = (idx_q == IW'(DIGITS - 1));
        frame_end = cnt_last && idx_last;

        cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_last) begin
            idx_d = idx_last ? '0 : idx_q + IW'(1);
        end

        pend_value_d = pend_value_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        if (load) begin
            pend_value_d = in_value;
            pend_blank_d = in_blank;
            pend_dp_d    = in_dp;
        end

        // A load landing on the boundary edge bypasses pending so it is not lost for a frame.
        disp_value_d = disp_value_q;
        disp_blank_d = disp_blank_q;
        disp_dp_d    = disp_dp_q;
        if (frame_end) begin
            disp_value_d = pend_value_d;
            disp_blank_d = pend_blank_d;
            disp_dp_d    = pend_dp_d;
        end

        nibble  = disp_value_q[{idx_q, 2'b00} +: 4];
        seg_raw = '0;
        dp_raw  = 1'b0;
        dig_raw = '0;
        if (cnt_q != '0) begin
            dig_raw = DIGITS'(1) << idx_q;
            if (!disp_blank_q[idx_q]) begin
                dp_raw = disp_dp_q[idx_q];
                if (!lz_dark) begin
                    seg_raw = hex7(nibble);
                end
            end
        end

        seg_d = seg_raw ^ SEG_OFF;
        dp_d  = dp_raw ^ DP_OFF;
        dig_d = dig_raw ^ DIG_OFF;
        fd_d  = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_blank_q <= '0;
            pend_dp_q    <= '0;
            disp_value_q <= '0;
            disp_blank_q <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            dig_q        <= DIG_OFF;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            disp_value_q <= disp_value_d;
            disp_blank_q <= disp_blank_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
            fd_q         <= fd_d;
        end
    end

    assign out_seg    = seg_q;
    assign out_dp     = dp_q;
    assign out_dig    = dig_q;
    assign frame_done = fd_q;

endmodule
